click_decoder: RTL
==================

Name: click_decoder

Overview:
Downstream consumer of the button debouncer's single-cycle pulse output.
- Classifies each press sequence as a single click or a double click, using a programmable cycle window.
- Emits one-cycle event strobes and keeps wrapping 8-bit tallies of each event type.
- Its outputs feed the display/LED control logic; it sits between the debouncer and the user-facing FSM.

Parameters:
WINDOW, 50_000_000, max cycles after the first pulse in which a second pulse counts as a double click (must be >= 2).
HOLDOFF, 25_000_000, cycles after a double click during which all pulses are ignored (must be >= 1).
TW, 26, width of the internal timer; must satisfy 2^TW > max(WINDOW, HOLDOFF).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
p_in  input  1  debounced press pulse, nominally one cycle wide.
single  output  1  one-cycle strobe: single click detected.
double  output  1  one-cycle strobe: double click detected.
busy  output  1  high whenever the FSM is not in IDLE.
sgl_cnt  output  8  count of single clicks, wraps 255->0.
dbl_cnt  output  8  count of double clicks, wraps 255->0.

Behaviour:
- All outputs are registered except busy, which is decoded directly from the state register.
- Reset is synchronous, active-high, and overrides everything, including mid-sequence:
  - state=IDLE, timer=0
  - single=0, double=0, sgl_cnt=0, dbl_cnt=0
- States: IDLE, WAIT, HOLD.
- IDLE:
  - p_in=1 at an edge (call it t0) -> WAIT, timer<=0.
  - p_in=0 -> stay.
- WAIT (timer counts 0..WINDOW-1, one per cycle):
  - p_in=1 -> double<=1, dbl_cnt<=dbl_cnt+1, state<=HOLD, timer<=0.
  - Else if timer==WINDOW-1 -> single<=1, sgl_cnt<=sgl_cnt+1, state<=IDLE.
  - Else timer<=timer+1.
  - A second pulse at edges t0+1 .. t0+WINDOW is a double click. At t0+WINDOW, p_in has priority over timeout.
  - If no second pulse arrives, single is high in the cycle following edge t0+WINDOW.
- HOLD:
  - p_in is ignored; it neither restarts the timer nor is queued.
  - timer increments each cycle; when timer==HOLDOFF-1 -> IDLE.
  - A pulse on the same edge HOLD->IDLE is dropped.
- Strobes:
  - single and double are each high for exactly one cycle and never high together.
  - Both are cleared to 0 on the edge after they are asserted.
- Latency:
  - double: 1 cycle after the edge sampling the second pulse.
  - single: WINDOW+1 cycles after the edge sampling the first pulse.
- Level input: p_in held high for N cycles is treated as N consecutive pulses. Example: a 2-cycle-high p_in in IDLE yields a double.
- A triple click produces exactly one double; the third pulse falls in HOLD and is dropped, provided it arrives within HOLDOFF.
- Counter wrap: sgl_cnt/dbl_cnt at 255 plus an event -> 0; no other side effect.
- busy=1 in WAIT and HOLD, 0 in IDLE.

Test Plan (sim params WINDOW=8, HOLDOFF=4, TW=4; clk period 10 ns):
1. Reset: assert reset for 2 cycles mid-WAIT (pulse, 3 cycles, reset) -> state IDLE, busy=0, single=double=0, both counts 0; no single strobe 8 cycles later.
2. Single click: one pulse at edge t0, none after -> single=1 only in the cycle after edge t0+8, sgl_cnt=1, dbl_cnt=0, busy back to 0 in the same cycle.
3. Double at window boundary: pulses at t0 and t0+8 -> double=1 in the cycle after t0+8, dbl_cnt=1, no single. Repeat with pulses at t0 and t0+9 -> single after t0+8, then a new WAIT starts at t0+9.
4. Triple click: pulses at t0, t0+2, t0+4 -> exactly one double (after t0+2); third pulse ignored; busy=0 from t0+7; sgl_cnt unchanged.
5. Held input: p_in high for 2 consecutive cycles from IDLE -> double after the second edge, dbl_cnt=1.
6. Wrap: 256 isolated single clicks -> sgl_cnt returns to 0, exactly 256 single strobes counted by the bench, double never asserted.

Source files
------------

// File: rtl/click_decoder.sv
// rtl/click_decoder.sv - single/double click classifier for debounced press pulses
// A second pulse within WINDOW cycles is a double click; a HOLDOFF lockout follows each double.
module click_decoder #(
  parameter int WINDOW  = 50_000_000,
  parameter int HOLDOFF = 25_000_000,
  parameter int TW      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_in,
  output logic       single,
  output logic       double,
  output logic       busy,
  output logic [7:0] sgl_cnt,
  output logic [7:0] dbl_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          single_q, single_d;
  logic          double_q, double_d;
  logic [7:0]    sgl_cnt_q, sgl_cnt_d;
  logic [7:0]    dbl_cnt_q, dbl_cnt_d;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    single_d  = 1'b0;
    double_d  = 1'b0;
    sgl_cnt_d = sgl_cnt_q;
    dbl_cnt_d = dbl_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (p_in) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        // A second pulse wins over the timeout on the final window edge.
        if (p_in) begin
          double_d  = 1'b1;
          dbl_cnt_d = dbl_cnt_q + 8'd1;
          state_d   = S_HOLD;
          timer_d   = '0;
        end else if (timer_q == WIN_LAST) begin
          single_d  = 1'b1;
          sgl_cnt_d = sgl_cnt_q + 8'd1;
          state_d   = S_IDLE;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        // Pulses here are dropped outright, including one on the exit edge.
        if (timer_q == HOLD_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      sgl_cnt_q <= 8'd0;
      dbl_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      single_q  <= single_d;
      double_q  <= double_d;
      sgl_cnt_q <= sgl_cnt_d;
      dbl_cnt_q <= dbl_cnt_d;
    end
  end

  assign single  = single_q;
  assign double  = double_q;
  assign sgl_cnt = sgl_cnt_q;
  assign dbl_cnt = dbl_cnt_q;
  assign busy    = (state_q != S_IDLE);

endmodule
